// File: rtl/aqed_resp_tracker.sv
// Receive-side A-QED tracker: captures the memory_core output at the original
// and duplicate tagged beat indices and reports equality, response bound and tag errors.
module aqed_resp_tracker #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int RESP_BOUND = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  in_valid,
  input  logic                  orig_issue,
  input  logic                  dup_issue,
  input  logic                  out_valid,
  input  logic [DATA_WIDTH-1:0] out_data,
  output logic                  orig_tagged,
  output logic                  orig_done,
  output logic                  qed_done,
  output logic                  qed_check,
  output logic                  resp_timeout,
  output logic                  proto_err,
  output logic [CNT_WIDTH-1:0]  in_cnt,
  output logic [CNT_WIDTH-1:0]  out_cnt,
  output logic [1:0]            state
);

  // Stream contract: in_valid marks one accepted write beat per cycle and
  // out_valid one produced output beat per cycle; there is no backpressure,
  // and output beat k always belongs to input beat k.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TAGGED = 2'd1,
    BOTH   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int BW = $clog2(RESP_BOUND + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [BW-1:0]        BOUND_MAX = BW'(RESP_BOUND);

  state_t                st;
  logic [CNT_WIDTH-1:0]  orig_idx;
  logic [CNT_WIDTH-1:0]  dup_idx;
  logic [DATA_WIDTH-1:0] orig_val;
  logic [DATA_WIDTH-1:0] dup_val;
  logic                  dup_done;
  logic [BW-1:0]         bound_cnt;

  logic in_sat;
  logic out_sat;
  logic tag_orig;
  logic tag_dup;
  logic orig_ok;
  logic dup_ok;
  logic tag_err;
  logic out_err;
  logic orig_cap;
  logic dup_cap;
  logic bound_inc;

  assign state = st;

  always_comb begin
    in_sat   = (in_cnt == CNT_MAX);
    out_sat  = (out_cnt == CNT_MAX);
    tag_orig = in_valid & orig_issue;
    tag_dup  = in_valid & dup_issue;
    orig_ok  = tag_orig & ~dup_issue & (st == IDLE) & ~in_sat;
    dup_ok   = tag_dup & ~orig_issue & (st == TAGGED) & ~in_sat;
    // A tag on a saturated counter has no unique index, so it is rejected.
    tag_err  = (tag_dup & (st == IDLE))
             | (tag_orig & (st != IDLE))
             | (tag_orig & tag_dup)
             | (tag_dup & ((st == BOTH) | (st == DONE)))
             | ((tag_orig | tag_dup) & in_sat);
    out_err  = out_valid & (out_cnt >= in_cnt);
    // Captures only match registered indices, so a same-cycle tag never hits.
    orig_cap = out_valid & orig_tagged & ~orig_done & (out_cnt == orig_idx);
    dup_cap  = out_valid & (st == BOTH) & ~dup_done & (out_cnt == dup_idx);
    bound_inc = ((st == TAGGED) | (st == BOTH)) & ~orig_done & (bound_cnt != BOUND_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st           <= IDLE;
      orig_idx     <= '0;
      dup_idx      <= '0;
      orig_val     <= '0;
      dup_val      <= '0;
      dup_done     <= 1'b0;
      bound_cnt    <= '0;
      orig_tagged  <= 1'b0;
      orig_done    <= 1'b0;
      qed_done     <= 1'b0;
      qed_check    <= 1'b0;
      resp_timeout <= 1'b0;
      proto_err    <= 1'b0;
      in_cnt       <= '0;
      out_cnt      <= '0;
    end else if (clk_en) begin
      if (in_valid && !in_sat) begin
        in_cnt <= in_cnt + 1'b1;
      end
      if (out_valid && !out_sat) begin
        out_cnt <= out_cnt + 1'b1;
      end
      if (tag_err || out_err) begin
        proto_err <= 1'b1;
      end
      if (orig_cap) begin
        orig_val  <= out_data;
        orig_done <= 1'b1;
      end
      if (dup_cap) begin
        dup_val  <= out_data;
        dup_done <= 1'b1;
      end
      if (bound_inc) begin
        bound_cnt <= bound_cnt + 1'b1;
        if (bound_cnt == BOUND_MAX - 1'b1) begin
          resp_timeout <= 1'b1;
        end
      end
      case (st)
        IDLE: begin
          if (orig_ok) begin
            orig_idx    <= in_cnt;
            orig_tagged <= 1'b1;
            bound_cnt   <= '0;
            st          <= TAGGED;
          end
        end
        TAGGED: begin
          if (dup_ok) begin
            dup_idx <= in_cnt;
            st      <= BOTH;
          end
        end
        BOTH: begin
          if (orig_done && dup_done) begin
            qed_done  <= 1'b1;
            qed_check <= (orig_val == dup_val);
            st        <= DONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
